// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES chunks,
// one chunk per stage, with a registered carry between stages and a global stall.
module rca_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;
    localparam int NSKEW = (STAGES > 1) ? STAGES - 1 : 1;

    // Handshake: a beat moves on a rising edge when valid && ready on that side.
    // The whole pipe advances together; in_ready mirrors the advance condition.

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  a_q [NSKEW];
    logic [WIDTH-1:0]  b_q [NSKEW];
    logic              ovf_q;

    logic              adv;
    logic [WIDTH-1:0]  a_src [STAGES];
    logic [WIDTH-1:0]  b_src [STAGES];
    logic [WIDTH-1:0]  s_src [STAGES];
    logic [WIDTH-1:0]  s_d   [STAGES];
    logic [CHUNK:0]    t_d   [STAGES];
    logic [STAGES-1:0] c_src;
    logic [STAGES-1:0] v_src;
    logic [STAGES-1:0] c_d;
    logic              msb_cin;

    assign adv       = !v_q[LAST] || out_ready;
    assign in_ready  = adv;
    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign c_out     = c_q[LAST];
    assign ovf       = ovf_q;

    always_comb begin
        c_src    = '0;
        v_src    = '0;
        c_d      = '0;
        a_src[0] = a;
        b_src[0] = sub ? ~b : b;
        s_src[0] = '0;
        c_src[0] = sub | c_in;
        v_src[0] = in_valid;
        // Stage k sees operands skewed through k registers and the partial sum so far
        for (int k = 1; k < STAGES; k++) begin
            a_src[k] = a_q[k-1];
            b_src[k] = b_q[k-1];
            s_src[k] = s_q[k-1];
            c_src[k] = c_q[k-1];
            v_src[k] = v_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            t_d[k] = {1'b0, a_src[k][k*CHUNK +: CHUNK]}
                   + {1'b0, b_src[k][k*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, c_src[k]};
            s_d[k] = s_src[k];
            s_d[k][k*CHUNK +: CHUNK] = t_d[k][CHUNK-1:0];
            c_d[k] = t_d[k][CHUNK];
        end
        // Carry into the MSB recovered from the MSB's own sum bit
        msb_cin = a_src[LAST][WIDTH-1] ^ b_src[LAST][WIDTH-1] ^ s_d[LAST][WIDTH-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                s_q[k] <= '0;
            end
            for (int k = 0; k < NSKEW; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else if (adv) begin
            v_q   <= v_src;
            c_q   <= c_d;
            ovf_q <= msb_cin ^ c_d[LAST];
            for (int k = 0; k < STAGES; k++) begin
                s_q[k] <= s_d[k];
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                a_q[k] <= a_src[k];
                b_q[k] <= b_src[k];
            end
        end
    end

endmodule
